chirp_gen: RTL and testbench

CHIRP_GEN -- requirements
Module: chirp_gen

---
 rtl/chirp_gen.sv | 169 ++++++++++++++++
 tb/tb_chirp_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/chirp_gen.sv
// rtl/chirp_gen.sv - linear-chirp sine generator with quarter-wave table and ready/valid output
module chirp_gen #(
  parameter int WIDTH       = 16,
  parameter int PHASE_WIDTH = 24,
  parameter int LUT_ADDR    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic [PHASE_WIDTH-1:0]        freq_start,
  input  logic [PHASE_WIDTH-1:0]        freq_step,
  input  logic [PHASE_WIDTH-1:0]        freq_stop,
  input  logic [15:0]                   num_samples,
  output logic signed [WIDTH-1:0]       out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          done
);
  localparam int  N       = 1 << LUT_ADDR;
  localparam int  MAG_W   = WIDTH - 1;
  localparam real AMP     = real'((1 << (WIDTH - 1)) - 1);
  localparam real HALF_PI = 1.5707963267948966;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [PHASE_WIDTH-1:0]  phase_q, phase_d, freq_q, freq_d;
  logic [PHASE_WIDTH-1:0]  step_q, step_d, stop_q, stop_d;
  logic [15:0]             num_q, num_d, iss_q, iss_d, acc_q, acc_d;
  logic [1:0]              quad_q, quad_d;
  logic [LUT_ADDR-1:0]     addr_q, addr_d;
  logic                    v1_q, v1_d;
  logic signed [WIDTH-1:0] out_q, out_d;
  logic                    out_valid_q, out_valid_d;

  logic                    start_go, advance, accept, last_accept, issue, load;
  logic [PHASE_WIDTH-1:0]  sum_a, sum_b, lim, phase_base;
  logic [PHASE_WIDTH:0]    freq_sum;
  logic [LUT_ADDR:0]       lut_idx;
  logic [MAG_W-1:0]        mag;
  logic signed [WIDTH-1:0] sample;
  logic [MAG_W-1:0]        lut [0:N];

  // Quarter-wave table k = 0..N, built from constant real math at elaboration.
  for (genvar k = 0; k <= N; k++) begin : g_lut
    assign lut[k] = MAG_W'($rtoi(AMP * $sin(HALF_PI * real'(k) / real'(N)) + 0.5));
  end

  assign start_go    = (state_q == IDLE) && start && !abort;
  assign advance     = !out_valid_q || out_ready;
  assign accept      = out_valid_q && out_ready;
  assign last_accept = accept && (acc_q == num_q - 16'd1);
  assign issue       = (state_q == RUN) && !abort && advance && (iss_q != num_q);

  // Odd quadrants read the table mirrored; the upper half negates.
  assign lut_idx = quad_q[0] ? ((LUT_ADDR + 1)'(N) - {1'b0, addr_q}) : {1'b0, addr_q};
  assign mag     = lut[lut_idx];
  assign sample  = quad_q[1] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      freq_q      <= '0;
      step_q      <= '0;
      stop_q      <= '0;
      num_q       <= '0;
      iss_q       <= '0;
      acc_q       <= '0;
      quad_q      <= '0;
      addr_q      <= '0;
      v1_q        <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      freq_q      <= freq_d;
      step_q      <= step_d;
      stop_q      <= stop_d;
      num_q       <= num_d;
      iss_q       <= iss_d;
      acc_q       <= acc_d;
      quad_q      <= quad_d;
      addr_q      <= addr_d;
      v1_q        <= v1_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_go) state_d = (num_samples == 16'd0) ? DONE : RUN;
      RUN: begin
        if (abort)            state_d = IDLE;
        else if (last_accept) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  always_comb begin
    phase_d     = phase_q;
    freq_d      = freq_q;
    step_d      = step_q;
    stop_d      = stop_q;
    num_d       = num_q;
    iss_d       = iss_q;
    acc_d       = acc_q;
    quad_d      = quad_q;
    addr_d      = addr_q;
    v1_d        = v1_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;

    // The start cycle itself issues sample 0 so the first output lands two cycles later.
    sum_a      = start_go ? freq_start : freq_q;
    sum_b      = start_go ? freq_step  : step_q;
    lim        = start_go ? freq_stop  : stop_q;
    phase_base = start_go ? '0 : phase_q;
    freq_sum   = {1'b0, sum_a} + {1'b0, sum_b};
    load       = start_go ? (num_samples != 16'd0) : issue;

    if (start_go) begin
      step_d  = freq_step;
      stop_d  = freq_stop;
      num_d   = num_samples;
      iss_d   = '0;
      acc_d   = '0;
      phase_d = '0;
    end

    if (state_q == RUN) begin
      if (abort) begin
        v1_d        = 1'b0;
        out_valid_d = 1'b0;
      end else begin
        if (advance) begin
          out_valid_d = v1_q;
          if (v1_q) out_d = sample;
          v1_d = 1'b0;
        end
        if (accept) acc_d = acc_q + 16'd1;
      end
    end

    if (load) begin
      quad_d  = phase_base[PHASE_WIDTH-1 -: 2];
      addr_d  = phase_base[PHASE_WIDTH-3 -: LUT_ADDR];
      v1_d    = 1'b1;
      phase_d = phase_base + sum_a;
      freq_d  = (freq_sum > {1'b0, lim}) ? lim : freq_sum[PHASE_WIDTH-1:0];
      iss_d   = (start_go ? 16'd0 : iss_q) + 16'd1;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_chirp_gen.sv
// tb/tb_chirp_gen.sv - directed, table-driven bench for chirp_gen
module tb_chirp_gen;
  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [23:0]        freq_start = '0;
  logic [23:0]        freq_step = '0;
  logic [23:0]        freq_stop = '0;
  logic [15:0]        num_samples = '0;
  logic signed [15:0] out;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic               busy;
  logic               done;

  chirp_gen dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .freq_start(freq_start), .freq_step(freq_step), .freq_stop(freq_stop),
    .num_samples(num_samples), .out(out), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    stall_lo;
    int    stall_hi;
    int    exp_done;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  int got[$];
  int first_v, done_cyc, last_hs, freeze_err, done_cnt, busy_cnt;

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  function automatic int lut_ref(input int k);
    return $rtoi(32767.0 * $sin(3.14159265358979 * real'(k) / 512.0) + 0.5);
  endfunction

  function automatic int sine_ref(input int ph);
    int q, a, m;
    q = (ph >> 22) & 3;
    a = (ph >> 14) & 255;
    m = lut_ref(q[0] ? 256 - a : a);
    return q[1] ? -m : m;
  endfunction

  task automatic start_sweep(input int fs, input int st, input int sp, input int n);
    @(negedge clk);
    freq_start = 24'(fs); freq_step = 24'(st); freq_stop = 24'(sp); num_samples = 16'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge of cycle 1 (start pulse was cycle 0); records handshakes.
  task automatic run_sweep(input int stall_lo, input int stall_hi, input int max_cyc);
    logic prev_v, prev_r;
    int   prev_o;
    got.delete();
    first_v = -1; done_cyc = -1; last_hs = -1;
    freeze_err = 0; done_cnt = 0; busy_cnt = 0;
    prev_v = 1'b0; prev_r = 1'b1; prev_o = 0;
    for (int cyc = 1; cyc < max_cyc; cyc++) begin
      out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
      if (prev_v && !prev_r && (!out_valid || int'(out) != prev_o)) freeze_err++;
      if (out_valid && first_v < 0) first_v = cyc;
      if (out_valid && out_ready) begin
        got.push_back(int'(out));
        last_hs = cyc;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      prev_v = out_valid; prev_r = out_ready; prev_o = int'(out);
      if (done_cyc >= 0 && cyc > done_cyc + 3) break;
      @(negedge clk);
    end
    out_ready = 1'b1;
  endtask

  initial begin
    vec_t vecs[2];
    int   exp16[16];
    int   ph, fr, nv, nb, nd;

    exp16 = '{0, 12539, 23170, 30273, 32767, 30273, 23170, 12539,
              0, -12539, -23170, -30273, -32767, -30273, -23170, -12539};
    vecs[0] = '{name: "free",  stall_lo: 1000, stall_hi: 0, exp_done: 18};
    vecs[1] = '{name: "stall", stall_lo: 3,    stall_hi: 6, exp_done: 22};

    repeat (2) @(negedge clk);
    check("rst_out", int'(out), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst = 1'b1;

    foreach (vecs[v]) begin
      start_sweep(24'h100000, 0, 24'h100000, 16);
      run_sweep(vecs[v].stall_lo, vecs[v].stall_hi, 80);
      check($sformatf("%s_count", vecs[v].name), got.size(), 16);
      check($sformatf("%s_first_valid", vecs[v].name), first_v, 2);
      for (int i = 0; i < 16 && i < got.size(); i++)
        check($sformatf("%s_out[%0d]", vecs[v].name, i), got[i], exp16[i]);
      check($sformatf("%s_done_cyc", vecs[v].name), done_cyc, vecs[v].exp_done);
      check($sformatf("%s_done_after_hs", vecs[v].name), done_cyc - last_hs, 1);
      check($sformatf("%s_done_cnt", vecs[v].name), done_cnt, 1);
      check($sformatf("%s_busy_cnt", vecs[v].name), busy_cnt, vecs[v].exp_done - 1);
      check($sformatf("%s_freeze", vecs[v].name), freeze_err, 0);
    end

    start_sweep(0, 24'h010000, 24'h040000, 64);
    run_sweep(1000, 0, 120);
    check("ramp_count", got.size(), 64);
    check("ramp_done_cyc", done_cyc, 66);
    if (got.size() > 2) check("ramp_hand_s2", got[2], 804);
    ph = 0; fr = 0;
    for (int i = 0; i < 64 && i < got.size(); i++) begin
      check($sformatf("ramp_out[%0d]", i), got[i], sine_ref(ph));
      ph = (ph + fr) & 24'hFFFFFF;
      fr = (fr + 24'h010000 > 24'h040000) ? 24'h040000 : fr + 24'h010000;
    end

    start_sweep(24'h100000, 0, 24'h100000, 0);
    nv = 0; nb = 0; done_cyc = -1; done_cnt = 0;
    for (int cyc = 1; cyc < 8; cyc++) begin
      if (out_valid) nv++;
      if (busy) nb++;
      if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
      @(negedge clk);
    end
    check("zero_valid", nv, 0);
    check("zero_busy", nb, 0);
    check("zero_done_cyc", done_cyc, 1);
    check("zero_done_cnt", done_cnt, 1);

    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    nv = 0; nb = 0; nd = 0;
    for (int cyc = 1; cyc < 6; cyc++) begin
      if (out_valid) nv++;
      if (busy) nb++;
      if (done) nd++;
      @(negedge clk);
    end
    check("abort_pri_busy", nb, 0);
    check("abort_pri_valid", nv, 0);
    check("abort_pri_done", nd, 0);

    start_sweep(24'h100000, 0, 24'h100000, 16);
    got.delete();
    for (int cyc = 1; cyc < 40; cyc++) begin
      start = (cyc == 3);
      freq_start = (cyc == 3) ? 24'h200000 : 24'h100000;
      if (out_valid && out_ready) got.push_back(int'(out));
      if (got.size() == 5) break;
      @(negedge clk);
    end
    start = 1'b0; freq_start = 24'h100000;
    @(negedge clk);
    abort = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    abort = 1'b0; out_ready = 1'b1;
    check("abort_valid_next", int'(out_valid), 0);
    check("abort_busy_next", int'(busy), 0);
    check("abort_hs_count", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++)
      check($sformatf("abort_out[%0d]", i), got[i], exp16[i]);
    nv = 0; nd = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (out_valid) nv++;
      if (done) nd++;
      @(negedge clk);
    end
    check("abort_no_valid", nv, 0);
    check("abort_no_done", nd, 0);
    start_sweep(24'h100000, 0, 24'h100000, 16);
    run_sweep(1000, 0, 80);
    check("restart_count", got.size(), 16);
    for (int i = 0; i < 16 && i < got.size(); i++)
      check($sformatf("restart_out[%0d]", i), got[i], exp16[i]);

    start_sweep(24'h100000, 0, 24'h100000, 16);
    repeat (4) @(negedge clk);
    check("pre_rst_valid", int'(out_valid), 1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_out", int'(out), 0);
    check("async_rst_valid", int'(out_valid), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_done", int'(done), 0);
    @(negedge clk);
    rst = 1'b1;
    nv = 0; nd = 0; nb = 0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      if (out_valid) nv++;
      if (done) nd++;
      if (busy) nb++;
      @(negedge clk);
    end
    check("post_rst_valid", nv, 0);
    check("post_rst_done", nd, 0);
    check("post_rst_busy", nb, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
